fwd_ctrl: RTL and testbench
===========================

FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 5, register-index width.
REQ-002 Parameter CNT_W, default 32, stall-counter width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 D_valid  in  1  decode slot holds a real instruction.
REQ-006 D_ra, D_rb  in  ADDR_SIZE each  decode source indices.
REQ-007 D_use_ra, D_use_rb  in  1 each  source actually read.
REQ-008 D_rd  in  ADDR_SIZE  decode destination index.
REQ-009 D_we, D_ld, D_jlx  in  1 each  writes rd / is load / writes r31 with pc+4.
REQ-010 flush  in  1  kill decode-slot instruction (taken branch/jump).
REQ-011 EX_D_bp, MEM_D_bp, WB_D_bp  out  2 each  bypass selects, {ra,rb} = {MSB,LSB}.
REQ-012 stall  out  1  hold fetch/decode, insert bubble into EX.
REQ-013 stall_cnt  out  CNT_W  count of stalled cycles.

Function
REQ-014 Three tracking entries EX, MEM, WB each SHALL hold {valid, rd, wr, ld, jlx}; wr = we&(rd!=0), jlx entries SHALL track rd=31.
REQ-015 Each cycle: WB<=MEM, MEM<=EX unconditionally; EX<=decode fields with valid=D_valid&!flush&!stall, otherwise bubble (valid=0).
REQ-016 Source match at stage S: D_valid & D_use_x & S.valid & (S.wr|S.jlx) & S.rd==D_rx & D_rx!=0.
REQ-017 Per source, bypass priority EX > MEM > WB; at most one of the three bits for that source SHALL be 1.
REQ-018 Load-use: EX match with EX.ld SHALL assert stall and suppress that source's EX bypass bit; next cycle the load sits in MEM and MEM bypass SHALL be selected.
REQ-019 jlx match at any stage SHALL assert stall (no bypass: stage data is not pc+4) until the entry leaves WB.
REQ-020 Matches on r0 or with D_use_x=0 SHALL never assert bypass or stall.
REQ-021 flush SHALL force stall=0 and all bypass bits 0 that cycle.
REQ-022 Outputs EX/MEM/WB_D_bp and stall are combinational from entries and decode inputs; zero latency.
REQ-023 stall_cnt SHALL increment by 1 on each cycle stall=1, saturating at all-ones.
REQ-024 Simultaneous ra and rb hazards: stall SHALL be OR of both; bypass bits resolved independently.

Reset
REQ-025 rst=1 SHALL clear all entry valid bits and stall_cnt to 0; with entries invalid, all bypass bits and stall SHALL read 0.
REQ-026 rst mid-stall SHALL drop the pending hazard; the decode instruction is not re-tracked.

Configuration
REQ-027 Macro FWD_BYPASS_EN defined: behaviour per REQ-017..REQ-019.
REQ-028 FWD_BYPASS_EN undefined: all bypass outputs tied 0; any match at EX, MEM or WB (REQ-016) SHALL assert stall (full interlock; WB write not visible same cycle).

Verification
REQ-029 add r3<-.. then add ..r3,r4 back-to-back -> EX_D_bp=2'b10, stall=0.
REQ-030 lw r5 then add ..r2,r5 -> cycle1 stall=1, EX_D_bp=0; cycle2 MEM_D_bp=2'b01, stall=0; stall_cnt=1.
REQ-031 add r7 in EX and MEM both (two writers), consumer reads r7 as ra -> EX_D_bp=2'b10, MEM_D_bp=0.
REQ-032 jal (jlx) then read r31 -> stall=1 for 3 cycles, then regfile value used, stall_cnt=3.
REQ-033 writer to r0 then read r0; consumer with flush=1 under load-use -> no bypass, stall=0.
REQ-034 FWD_BYPASS_EN undefined, add r3 then read r3 -> stall=1 for 3 cycles, all bp=0; rst during stall -> stall=0 next cycle.

Source files
------------

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: hazard detection and operand-forwarding control for a 5-stage pipe.
// Tracks the destinations of the instructions in EX, MEM and WB and compares
// them against the decode-slot sources. Produces per-stage bypass selects,
// a stall request and a saturating count of stalled cycles.
//
// Build option: define FWD_BYPASS_EN to enable forwarding (EX > MEM > WB,
// with load-use and jlx stalls). With it undefined the block is a full
// interlock: every bypass select reads 0 and any producer match stalls.
module fwd_ctrl #(
  parameter int ADDR_SIZE = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 D_valid,
  input  logic [ADDR_SIZE-1:0] D_ra,
  input  logic [ADDR_SIZE-1:0] D_rb,
  input  logic                 D_use_ra,
  input  logic                 D_use_rb,
  input  logic [ADDR_SIZE-1:0] D_rd,
  input  logic                 D_we,
  input  logic                 D_ld,
  input  logic                 D_jlx,
  input  logic                 flush,
  output logic [1:0]           EX_D_bp,
  output logic [1:0]           MEM_D_bp,
  output logic [1:0]           WB_D_bp,
  output logic                 stall,
  output logic [CNT_W-1:0]     stall_cnt
);

  // One tracking entry per downstream stage; index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic                 vld;
    logic [ADDR_SIZE-1:0] rd;
    logic                 wr;
    logic                 ld;
    logic                 jlx;
  } ent_t;

  localparam int NSTG = 3;
  localparam int EX   = 0;

  ent_t             ent_q [NSTG];
  ent_t             ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NSTG-1:0] m_a, m_b;     // per-stage source matches
  logic [NSTG-1:0] jl;           // per-stage jlx flag
  logic [NSTG-1:0] sel_a, sel_b; // per-stage bypass selects, one-hot or zero
  logic            hz_a, hz_b;   // per-source stall request
  logic            ld_ex;

  // Source match against every tracked stage; r0 and unread sources never match.
  always_comb begin
    for (int s = 0; s < NSTG; s++) begin
      m_a[s] = D_valid & D_use_ra & ent_q[s].vld & (ent_q[s].wr | ent_q[s].jlx)
             & (ent_q[s].rd == D_ra) & (D_ra != '0);
      m_b[s] = D_valid & D_use_rb & ent_q[s].vld & (ent_q[s].wr | ent_q[s].jlx)
             & (ent_q[s].rd == D_rb) & (D_rb != '0);
      jl[s]  = ent_q[s].jlx;
    end
    ld_ex = ent_q[EX].ld;
  end

`ifdef FWD_BYPASS_EN
  // Newest producer wins. A load in EX has no data yet, and a jlx stage only
  // holds its ALU result, not pc+4, so neither can be forwarded; both stall.
  function automatic logic [NSTG:0] resolve(input logic [NSTG-1:0] m,
                                            input logic [NSTG-1:0] j,
                                            input logic            ld);
    logic [NSTG-1:0] sel;
    logic            hz;
    sel = '0;
    hz  = |(m & j) | (m[0] & ld);
    if (m[0]) begin
      if (!ld && !j[0]) sel[0] = 1'b1;
    end else if (m[1]) begin
      if (!j[1]) sel[1] = 1'b1;
    end else if (m[2]) begin
      if (!j[2]) sel[2] = 1'b1;
    end
    return {hz, sel};
  endfunction

  // Resolve ra and rb independently; the stall is the OR of both.
  always_comb begin
    {hz_a, sel_a} = resolve(m_a, jl, ld_ex);
    {hz_b, sel_b} = resolve(m_b, jl, ld_ex);
  end
`else
  // Full interlock: nothing is forwarded and any producer match stalls.
  // Load-use and jlx hazards are a subset of "any match" here.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    hz_a  = |m_a | (m_a[0] & ld_ex) | |(m_a & jl);
    hz_b  = |m_b | (m_b[0] & ld_ex) | |(m_b & jl);
  end
`endif

  // Drive outputs; a flushed decode slot neither stalls nor forwards.
  always_comb begin
    EX_D_bp  = 2'b00;
    MEM_D_bp = 2'b00;
    WB_D_bp  = 2'b00;
    stall    = 1'b0;
    if (!flush) begin
      EX_D_bp  = {sel_a[0], sel_b[0]};
      MEM_D_bp = {sel_a[1], sel_b[1]};
      WB_D_bp  = {sel_a[2], sel_b[2]};
      stall    = hz_a | hz_b;
    end
  end

  // Next EX entry from decode; jlx always writes r31, r0 writes are dropped.
  always_comb begin
    ex_d     = '0;
    ex_d.vld = D_valid & ~flush & ~stall;
    ex_d.rd  = D_jlx ? {ADDR_SIZE{1'b1}} : D_rd;
    ex_d.wr  = D_we & (ex_d.rd != '0);
    ex_d.ld  = D_ld;
    ex_d.jlx = D_jlx;
  end

  // Advance the tracking pipe every cycle; a stall only bubbles EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSTG; s++) ent_q[s] <= '0;
    end else begin
      ent_q[2] <= ent_q[1];
      ent_q[1] <= ent_q[0];
      ent_q[0] <= ex_d;
    end
  end

  // Saturating stall counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: table-driven check of fwd_ctrl. Each row carries the decode
// inputs plus the expected outputs for both builds (forwarding / interlock);
// expectations are queued when a row is driven and compared on the falling
// edge. A second instance with a 2-bit counter checks saturation.
module tb_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst, D_valid, D_use_ra, D_use_rb, D_we, D_ld, D_jlx, flush;
  logic [4:0] D_ra, D_rb, D_rd;
  logic [1:0] EX_D_bp, MEM_D_bp, WB_D_bp;
  logic       stall;
  logic [31:0] stall_cnt;
  logic [1:0] s_ex, s_mem, s_wb;
  logic       s_stall;
  logic [1:0] s_cnt;

  always #5 clk = ~clk;

  fwd_ctrl #(.ADDR_SIZE(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .D_valid(D_valid), .D_ra(D_ra), .D_rb(D_rb),
    .D_use_ra(D_use_ra), .D_use_rb(D_use_rb), .D_rd(D_rd), .D_we(D_we),
    .D_ld(D_ld), .D_jlx(D_jlx), .flush(flush), .EX_D_bp(EX_D_bp),
    .MEM_D_bp(MEM_D_bp), .WB_D_bp(WB_D_bp), .stall(stall), .stall_cnt(stall_cnt));

  fwd_ctrl #(.ADDR_SIZE(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .D_valid(D_valid), .D_ra(D_ra), .D_rb(D_rb),
    .D_use_ra(D_use_ra), .D_use_rb(D_use_rb), .D_rd(D_rd), .D_we(D_we),
    .D_ld(D_ld), .D_jlx(D_jlx), .flush(flush), .EX_D_bp(s_ex),
    .MEM_D_bp(s_mem), .WB_D_bp(s_wb), .stall(s_stall), .stall_cnt(s_cnt));

  typedef struct {
    logic       rst, v;
    logic [4:0] ra, rb;
    logic       ura, urb;
    logic [4:0] rd;
    logic       we, ld, jlx, fl;
    logic [1:0] exb, memb, wbb;
    logic       stb, sti;
    int         cntb, cnti;
  } vec_t;

  typedef struct {
    int         tag;
    logic [6:0] outs;
    int         cnt;
  } exp_t;

  vec_t vt[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Append one table row: inputs, then forwarding-build outputs, interlock
  // stall, and expected stall_cnt for each build (-1 = not checked).
  task automatic row(input int rs, v, ra, rb, ura, urb, rd, we, ld, jlx, fl,
                     input int exb, memb, wbb, stb, sti, cb, ci);
    vec_t x;
    x.rst = 1'(rs);  x.v = 1'(v);     x.ra = 5'(ra);   x.rb = 5'(rb);
    x.ura = 1'(ura); x.urb = 1'(urb); x.rd = 5'(rd);   x.we = 1'(we);
    x.ld = 1'(ld);   x.jlx = 1'(jlx); x.fl = 1'(fl);
    x.exb = 2'(exb); x.memb = 2'(memb); x.wbb = 2'(wbb);
    x.stb = 1'(stb); x.sti = 1'(sti); x.cntb = cb; x.cnti = ci;
    vt.push_back(x);
  endtask

  task automatic drive(input vec_t x, input int tag);
    exp_t e;
    rst = x.rst; D_valid = x.v; D_ra = x.ra; D_rb = x.rb;
    D_use_ra = x.ura; D_use_rb = x.urb; D_rd = x.rd; D_we = x.we;
    D_ld = x.ld; D_jlx = x.jlx; flush = x.fl;
    e.tag = tag;
`ifdef FWD_BYPASS_EN
    e.outs = {x.exb, x.memb, x.wbb, x.stb};
    e.cnt  = x.cntb;
`else
    e.outs = {6'b000000, x.sti};
    e.cnt  = x.cnti;
`endif
    sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  // Compare combinational outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t       e;
      logic [6:0] got;
      e   = sbq.pop_front();
      got = {EX_D_bp, MEM_D_bp, WB_D_bp, stall};
      checks++;
      if (got !== e.outs) begin
        errors++;
        $display("FAIL outs step %0d: got ex/mem/wb/stall=%b want %b", e.tag, got, e.outs);
      end
      if (e.cnt >= 0) begin
        checks++;
        if (stall_cnt !== 32'(e.cnt)) begin
          errors++;
          $display("FAIL stall_cnt step %0d: got %0d want %0d", e.tag, stall_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; D_valid = 0; D_ra = 0; D_rb = 0; D_use_ra = 0; D_use_rb = 0;
    D_rd = 0; D_we = 0; D_ld = 0; D_jlx = 0; flush = 0;

    //   rs v  ra rb ua ub rd we ld jx fl  exb memb wbb stb sti  cb ci
    // reset state, back-to-back ALU dependency walking EX -> MEM -> WB
    row(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  1, 2, 1, 1,  3, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  3, 4, 1, 1,  6, 1, 0, 0, 0,  2, 0, 0, 0, 1,  0, 0);
    row(0, 1,  3, 4, 1, 1,  6, 1, 0, 0, 0,  0, 2, 0, 0, 1,  0, 1);
    row(0, 1,  3, 4, 1, 1,  6, 1, 0, 0, 0,  0, 0, 2, 0, 1,  0, 2);
    row(0, 1,  3, 4, 1, 1,  6, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 3);
    // load-use on rb
    row(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 3);
    row(0, 1,  1, 0, 1, 0,  5, 1, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  2, 5, 1, 1,  8, 1, 0, 0, 0,  0, 0, 0, 1, 1,  0, 0);
    row(0, 1,  2, 5, 1, 1,  8, 1, 0, 0, 0,  0, 1, 0, 0, 1,  1, 1);
    row(0, 1,  2, 5, 1, 1,  8, 1, 0, 0, 0,  0, 0, 1, 0, 1,  1, 2);
    row(0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 3);
    // two writers of r7 in EX and MEM: newest wins
    row(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 3);
    row(0, 1,  1, 2, 0, 0,  7, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  1, 2, 0, 0,  7, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  7, 9, 1, 1, 10, 1, 0, 0, 0,  2, 0, 0, 0, 1,  0, 0);
    row(0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1);
    // jal then read r31: stall until it leaves WB
    row(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1);
    row(0, 1,  0, 0, 0, 0,  0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1, 31, 0, 1, 0,  4, 1, 0, 0, 0,  0, 0, 0, 1, 1,  0, 0);
    row(0, 1, 31, 0, 1, 0,  4, 1, 0, 0, 0,  0, 0, 0, 1, 1,  1, 1);
    row(0, 1, 31, 0, 1, 0,  4, 1, 0, 0, 0,  0, 0, 0, 1, 1,  2, 2);
    row(0, 1, 31, 0, 1, 0,  4, 1, 0, 0, 0,  0, 0, 0, 0, 0,  3, 3);
    // r0 writer/reader, flush under load-use, MEM hit, unread source
    row(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  3, 3);
    row(0, 1,  0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  0, 0, 1, 1,  2, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  0, 0, 0, 0,  5, 1, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  5, 0, 1, 0,  9, 1, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  5, 0, 1, 0,  9, 1, 0, 0, 0,  0, 2, 0, 0, 1,  0, 0);
    row(0, 1,  5, 0, 0, 0,  9, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1);
    // ra hits MEM while rb hits EX: independent resolution
    row(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1);
    row(0, 1,  0, 0, 0, 0,  3, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  0, 0, 0, 0,  4, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  3, 4, 1, 1, 11, 1, 0, 0, 0,  1, 2, 0, 0, 1,  0, 0);
    row(0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1);
    // reset while the consumer is stalled: hazard dropped next cycle
    row(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1);
    row(0, 1,  0, 0, 0, 0,  3, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  3, 0, 1, 0, 12, 1, 0, 0, 0,  2, 0, 0, 0, 1,  0, 0);
    row(1, 1,  3, 0, 1, 0, 12, 1, 0, 0, 0,  0, 2, 0, 0, 1,  0, 1);
    row(0, 1,  3, 0, 1, 0, 12, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < vt.size(); i++) drive(vt[i], i);

    // Hand sequence: two jal/read-r31 episodes, six stalled cycles in total,
    // so the 2-bit counter instance must stick at 3.
    vt.delete();
    row(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    row(0, 1,  0, 0, 0, 0,  0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0);
    for (int k = 0; k < 3; k++)
      row(0, 1, 31, 0, 1, 0, 4, 1, 0, 0, 0,  0, 0, 0, 1, 1,  k, k);
    row(0, 1, 31, 0, 1, 0,  4, 1, 0, 0, 0,  0, 0, 0, 0, 0,  3, 3);
    row(0, 1,  0, 0, 0, 0,  0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  3, 3);
    for (int k = 0; k < 3; k++)
      row(0, 1, 31, 0, 1, 0, 4, 1, 0, 0, 0,  0, 0, 0, 1, 1,  3 + k, 3 + k);
    row(0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  6, 6);
    for (int i = 0; i < vt.size(); i++) drive(vt[i], 100 + i);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end

    @(negedge clk);
    checks++;
    if (s_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_cnt: got %0d want 3", s_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
